// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between NUM_CORES requesters and one
// single-port data memory with a combinational read path.
//
// Each transaction runs IDLE -> ACCESS -> RESP. In IDLE a winner is chosen
// round-robin (the last winner has lowest priority). In ACCESS the winner's
// command is driven onto the memory port. In RESP a one-cycle ack goes back
// to the winner. Addresses at or above MEM_DEPTH are blocked and raise a
// sticky error flag.
//
// Ports:
//   clk, reset      single rising-edge clock, synchronous active-high reset
//   core_req/we     per-core request and write-enable (1 = write)
//   core_addr/wdata packed per-core address / write data, core i at [i*W +: W]
//   core_ack        registered one-cycle completion pulse to the winner
//   core_rdata      shared read data, valid while the winner's ack is high
//   mem_write/read  memory strobes (asserted only in ACCESS)
//   mem_address     memory address
//   mem_data_in     memory write data
//   mem_data_out    memory read data (combinational)
//   err_oob         sticky out-of-range flag, cleared only by reset
//   busy            high in ACCESS and RESP
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1001
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_write,
    output logic                        mem_read,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out,
    output logic                        err_oob,
    output logic                        busy
);

    localparam int PTR_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [PTR_W-1:0]      r_gnt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NUM_CORES-1:0]  r_ack;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;

    logic [ADDR_W-1:0]     w_addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]     w_wdata_arr [NUM_CORES];
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_sel_we;
    logic                  w_in_range;
    logic [NUM_CORES-1:0]  w_gnt_onehot;
    logic [NUM_CORES-1:0]  w_rot;
    logic [PTR_W-1:0]      w_pick;
    int                    w_off;
    int                    w_sum;

    // Unpack the flat per-core buses into arrays indexed by core number.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_addr_arr[i]  = core_addr[i*ADDR_W +: ADDR_W];
            w_wdata_arr[i] = core_wdata[i*DATA_W +: DATA_W];
        end
    end

    assign w_sel_addr   = w_addr_arr[r_gnt];
    assign w_sel_wdata  = w_wdata_arr[r_gnt];
    assign w_sel_we     = core_we[r_gnt];
    assign w_in_range   = 64'(w_sel_addr) < 64'(MEM_DEPTH);
    assign w_gnt_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_gnt;

    // Round-robin pick: rotate the request vector so bit 0 is core rr_ptr+1,
    // take the lowest set bit, then map the offset back to a core index.
    always_comb begin
        w_rot  = NUM_CORES'({core_req, core_req} >> (int'(r_rr_ptr) + 1));
        w_off  = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i;
            end
        end
        w_sum = int'(r_rr_ptr) + 1 + w_off;
        if (w_sum >= NUM_CORES) begin
            w_sum = w_sum - NUM_CORES;
        end
        w_pick = PTR_W'(w_sum);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (|core_req) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Memory port is live only in ACCESS. Gating with reset keeps a reset
    // that lands on the ACCESS cycle from committing a write at that edge.
    always_comb begin
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        if (r_state == S_ACCESS && !reset) begin
            mem_address = w_sel_addr;
            mem_data_in = w_sel_wdata;
            mem_write   = w_sel_we & w_in_range;
            mem_read    = ~w_sel_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_rr_ptr <= PTR_W'(NUM_CORES - 1);
            r_ack    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|core_req) begin
                        r_gnt <= w_pick;
                    end
                end
                S_ACCESS: begin
                    r_ack <= w_gnt_onehot;
                    // Writes leave the read-data bus untouched.
                    if (!w_sel_we) begin
                        r_rdata <= w_in_range ? mem_data_out : '0;
                    end
                    if (!w_in_range) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= r_gnt;
                end
                default: ;
            endcase
        end
    end

    assign core_ack   = r_ack;
    assign core_rdata = r_rdata;
    assign err_oob    = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed testbench for mem_arbiter with a behavioural
// single-port memory (combinational read, write on rising edge).
module tb_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    core_req;
    logic [NC-1:0]    core_we;
    logic [NC*AW-1:0] core_addr;
    logic [NC*DW-1:0] core_wdata;
    logic [NC-1:0]    core_ack;
    logic [DW-1:0]    core_rdata;
    logic             mem_write;
    logic             mem_read;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_data_in;
    logic [DW-1:0]    mem_data_out;
    logic             err_oob;
    logic             busy;

    logic [DW-1:0]    mem [0:65535];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_data_in;
    end

    mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1001)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .err_oob(err_oob), .busy(busy)
    );

    task automatic do_reset();
        core_req = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one transaction for a single core and reports what was observed.
    task automatic run_txn(input int c, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, output int lat,
                           output logic [NC-1:0] ackv, output logic [DW-1:0] rd,
                           output int wcnt, output logic [AW-1:0] waddr);
        lat = -1; ackv = '0; rd = '0; wcnt = 0; waddr = '0;
        @(posedge clk); #1;
        core_we[c] = we;
        core_addr[c*AW +: AW] = addr;
        core_wdata[c*DW +: DW] = wd;
        core_req[c] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (mem_write) begin wcnt++; waddr = mem_address; end
            if (core_ack != '0) begin
                lat = k; ackv = core_ack; rd = core_rdata;
                break;
            end
        end
        core_req[c] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        checks++; if (core_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", core_ack); end
        checks++; if (core_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %0h expected 0", core_rdata); end
        checks++; if (err_oob !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_oob); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({mem_write, mem_read, mem_address, mem_data_in} !== 34'd0) begin
            failures++; $display("FAIL reset_mem_port: got w=%b r=%b a=%0d d=%0h expected all 0",
                                 mem_write, mem_read, mem_address, mem_data_in);
        end
    endtask

    task automatic test_read();
        int lat, wcnt; logic [NC-1:0] ackv; logic [DW-1:0] rd; logic [AW-1:0] waddr;
        run_txn(1, 1'b0, 16'd998, 16'd0, lat, ackv, rd, wcnt, waddr);
        checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency: got %0d expected 2", lat); end
        checks++; if (ackv !== 4'b0010) begin failures++; $display("FAIL read_ack: got %b expected 0010", ackv); end
        checks++; if (rd !== 16'd4298) begin failures++; $display("FAIL read_data: got %0d expected 4298", rd); end
        checks++; if (wcnt !== 0) begin failures++; $display("FAIL read_no_write: got %0d write cycles expected 0", wcnt); end
    endtask

    task automatic test_write_readback();
        int lat, wcnt; logic [NC-1:0] ackv; logic [DW-1:0] rd; logic [AW-1:0] waddr;
        run_txn(0, 1'b1, 16'd999, 16'd123, lat, ackv, rd, wcnt, waddr);
        checks++; if (wcnt !== 1) begin failures++; $display("FAIL wr_cycles: got %0d expected 1", wcnt); end
        checks++; if (waddr !== 16'd999) begin failures++; $display("FAIL wr_addr: got %0d expected 999", waddr); end
        checks++; if (ackv !== 4'b0001) begin failures++; $display("FAIL wr_ack: got %b expected 0001", ackv); end
        checks++; if (mem[999] !== 16'd123) begin failures++; $display("FAIL wr_mem: got %0d expected 123", mem[999]); end
        run_txn(0, 1'b0, 16'd999, 16'd0, lat, ackv, rd, wcnt, waddr);
        checks++; if (rd !== 16'd123) begin failures++; $display("FAIL rb_data: got %0d expected 123", rd); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL rb_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] vals [NC];
        logic [NC-1:0] pend;
        logic [NC-1:0] exp_ack;
        int cyc, last, idx;
        bit seen;
        vals[0] = 16'h0007; vals[1] = 16'h0107; vals[2] = 16'h0207; vals[3] = 16'h0307;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            mem[10 + i] = vals[i];
            core_we[i] = 1'b0;
            core_addr[i*AW +: AW] = AW'(10 + i);
        end
        core_req = 4'hF;
        pend = '0; cyc = 0; last = 0;
        for (int k = 0; k < 8; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 12 && !seen; w++) begin
                @(posedge clk); #1;
                cyc++;
                core_req = core_req | pend;
                pend = '0;
                if (mem_write) begin failures++; checks++; $display("FAIL rr_write: got mem_write=1 expected 0"); end
                if (core_ack != '0) seen = 1'b1;
            end
            if (!seen) begin
                checks++; failures++;
                $display("FAIL rr_timeout: got no ack for grant %0d expected ack within 12 cycles", k);
                core_req = '0;
                return;
            end
            idx = k % NC;
            exp_ack = NC'(1) << idx;
            checks++; if (core_ack !== exp_ack) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", k, core_ack, exp_ack); end
            checks++; if (core_rdata !== vals[idx]) begin failures++; $display("FAIL rr_data[%0d]: got %0h expected %0h", k, core_rdata, vals[idx]); end
            if (k > 0) begin
                checks++; if (cyc - last !== 3) begin failures++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", k, cyc - last); end
            end
            last = cyc;
            core_req[idx] = 1'b0;
            pend[idx] = 1'b1;
        end
        core_req = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_out_of_range();
        int lat, wcnt; logic [NC-1:0] ackv; logic [DW-1:0] rd; logic [AW-1:0] waddr;
        mem[1000] = 16'hAAAA;
        mem[1001] = 16'hBBBB;
        checks++; if (err_oob !== 1'b0) begin failures++; $display("FAIL oob_err_before: got %b expected 0", err_oob); end
        run_txn(2, 1'b1, 16'd1001, 16'd55, lat, ackv, rd, wcnt, waddr);
        checks++; if (wcnt !== 0) begin failures++; $display("FAIL oob_wr_blocked: got %0d write cycles expected 0", wcnt); end
        checks++; if (ackv !== 4'b0100) begin failures++; $display("FAIL oob_wr_ack: got %b expected 0100", ackv); end
        checks++; if (mem[1000] !== 16'hAAAA) begin failures++; $display("FAIL oob_mem1000: got %0h expected aaaa", mem[1000]); end
        checks++; if (mem[1001] !== 16'hBBBB) begin failures++; $display("FAIL oob_mem1001: got %0h expected bbbb", mem[1001]); end
        checks++; if (rd !== 16'h0307) begin failures++; $display("FAIL oob_wr_rdata_hold: got %0h expected 307", rd); end
        checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_err_set: got %b expected 1", err_oob); end
        run_txn(2, 1'b0, 16'd1001, 16'd0, lat, ackv, rd, wcnt, waddr);
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL oob_rd_data: got %0h expected 0", rd); end
        checks++; if (ackv !== 4'b0100) begin failures++; $display("FAIL oob_rd_ack: got %b expected 0100", ackv); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_err_sticky: got %b expected 1", err_oob); end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        mem[500] = 16'h1234;
        @(posedge clk); #1;
        core_we[3] = 1'b1;
        core_addr[3*AW +: AW] = 16'd500;
        core_wdata[3*DW +: DW] = 16'd77;
        core_req = 4'b1000;
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL mid_access_write: got %b expected 1", mem_write); end
        reset = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL mid_write_forced_low: got %b expected 0", mem_write); end
        core_req = '0;
        @(posedge clk); #1;
        checks++; if (mem[500] !== 16'h1234) begin failures++; $display("FAIL mid_mem500: got %0h expected 1234", mem[500]); end
        checks++; if (err_oob !== 1'b0) begin failures++; $display("FAIL mid_err_cleared: got %b expected 0", err_oob); end
        checks++; if ({busy, core_ack} !== 5'b0) begin failures++; $display("FAIL mid_busy_ack: got %b expected 00000", {busy, core_ack}); end
        checks++; if (core_rdata !== 16'h0000) begin failures++; $display("FAIL mid_rdata: got %0h expected 0", core_rdata); end
        reset = 1'b0;
        core_we[0] = 1'b0;
        core_addr[0 +: AW] = 16'd999;
        core_req = 4'b1001;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(posedge clk); #1;
            if (core_ack != '0) seen = 1'b1;
        end
        checks++; if (core_ack !== 4'b0001) begin failures++; $display("FAIL mid_first_grant: got %b expected 0001", core_ack); end
        core_req[0] = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(posedge clk); #1;
            if (core_ack != '0) seen = 1'b1;
        end
        checks++; if (core_ack !== 4'b1000) begin failures++; $display("FAIL mid_second_grant: got %b expected 1000", core_ack); end
        core_req = '0;
        checks++; if (mem[500] !== 16'd77) begin failures++; $display("FAIL mid_retry_write: got %0d expected 77", mem[500]); end
    endtask

    task automatic test_idle();
        int bad;
        core_req = '0;
        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || mem_write !== 1'b0 || core_ack !== 4'b0000) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[998] = 16'd4298;
        reset = 1'b1;
        core_req = '0;
        core_we = '0;
        core_addr = '0;
        core_wdata = '0;
        test_reset();
        test_read();
        test_write_readback();
        test_round_robin();
        test_out_of_range();
        test_reset_mid_op();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
